// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// State codes, the nop word loaded on reset and the default boot pc.
package ifetch_unit_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2,
      S_ERR   = 2'd3
   } if_state_t;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_timeout_cnt.sv
// Counts consecutive un-acked request cycles; expire flags the last allowed one.
// Registered count, combinational expire; clear has priority over inc.
module ifetch_timeout_cnt #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expire = (cnt == 8'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/ifetch_unit.sv
// PC register + fetch sequencer (IFETCH_MISALIGN_CHECK_EN adds a misaligned-npc trap).
// Latency: req one cycle after reset release, inst_valid the cycle after ack.
// Backpressure: pc and inst hold while inst_valid && !inst_ready; one fetch in flight.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] npc,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        fetch_err,
   output logic        fetch_misalign
);

   if_state_t state;
   logic      cnt_clear;
   logic      cnt_inc;
   logic      cnt_expire;

   // The counter only runs while waiting on imem; any other state or an ack rearms it.
   assign cnt_clear = (state != S_REQ) || imem_ack;
   assign cnt_inc   = (state == S_REQ) && !imem_ack;

   ifetch_timeout_cnt #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .expire(cnt_expire)
   );

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic misalign_q;
   assign fetch_misalign = misalign_q;
`else
   assign fetch_misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_BOOT;
         pc         <= RESET_PC;
         inst       <= INST_NOP;
         inst_valid <= 1'b0;
         imem_req   <= 1'b0;
         fetch_err  <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_BOOT: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
            end
            S_REQ: begin
               // An ack on the final allowed cycle still wins over the timeout.
               if (imem_ack) begin
                  inst       <= imem_rdata;
                  imem_req   <= 1'b0;
                  inst_valid <= 1'b1;
                  state      <= S_VALID;
               end else if (cnt_expire) begin
                  fetch_err <= 1'b1;
                  imem_req  <= 1'b0;
                  state     <= S_ERR;
               end
            end
            S_VALID: begin
               if (inst_ready) begin
                  pc         <= npc;
                  inst_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
                  if (npc[1:0] != 2'b00) begin
                     misalign_q <= 1'b1;
                     state      <= S_ERR;
                  end else begin
                     imem_req <= 1'b1;
                     state    <= S_REQ;
                  end
`else
                  imem_req <= 1'b1;
                  state    <= S_REQ;
`endif
               end
            end
            default: begin
               imem_req   <= 1'b0;
               inst_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr = word_addr(pc);

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized fetch/accept traffic against a pc-sequence model with a fetch scoreboard.
module tb_ifetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] npc;
   logic [31:0] pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        fetch_err;
   logic        fetch_misalign;

   int n_checks = 0;
   int n_fail   = 0;
   int n_accept = 0;

   // Environment configuration and model state
   logic [31:0] exp_pc = RST_PC;
   logic [63:0] sb_q[$];
   int  ack_fixed   = 0;
   int  ack_dmax    = 0;
   int  stall_fixed = 0;
   int  stall_max   = 0;
   bit  never_ack   = 1'b0;
   bit  mis_on      = 1'b0;
   int  req_cyc     = 0;
   int  ack_delay   = 0;
   int  stall_left  = 0;

   always #5 clk = ~clk;

   // NPC behaviour: sequential +4 with a branch, a jump to the top of memory, and an optional misaligned target.
   function automatic logic [31:0] npc_f(input logic [31:0] p, input bit mis);
      if (mis && p == 32'h0000_0104) return 32'h0000_0102;
      if (p == 32'h0000_0008)        return 32'h0000_0100;
      if (p == 32'h0000_0110)        return 32'hFFFF_FFF8;
      return p + 32'd4;
   endfunction

   assign npc = npc_f(pc, mis_on);

   ifetch_unit #(
      .RESET_PC   (RST_PC),
      .ACK_TIMEOUT(4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .npc           (npc),
      .pc            (pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .inst          (inst),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .fetch_err     (fetch_err),
      .fetch_misalign(fetch_misalign)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int pick_ack_delay();
      return (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(ack_dmax, 0));
   endfunction

   // imem responder and decode consumer; drives inputs on the falling edge.
   always @(negedge clk) begin
      imem_ack = 1'b0;
      if (rst_n && imem_req) begin
         chk("req_addr", imem_addr, {exp_pc[31:2], 2'b00});
         if (!never_ack && req_cyc >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            sb_q.push_back({exp_pc, imem_rdata});
            req_cyc    = 0;
            ack_delay  = pick_ack_delay();
         end else begin
            req_cyc++;
         end
      end else begin
         req_cyc    = 0;
         imem_ack   = 1'($urandom_range(1, 0));
         imem_rdata = $urandom;
      end
      if (rst_n && inst_valid) begin
         if (stall_left == 0) begin
            inst_ready = 1'b1;
            exp_pc     = npc_f(exp_pc, mis_on);
            n_accept++;
            stall_left = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(stall_max, 0));
         end else begin
            inst_ready = 1'b0;
            stall_left--;
         end
      end else begin
         inst_ready = 1'($urandom_range(1, 0));
      end
   end

   // Monitor: the held word must match the oldest outstanding fetch until decode takes it.
   always @(negedge clk) begin
      #2;
      if (rst_n && inst_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: inst_valid=1 pc=%h with no fetch outstanding", pc);
         end else begin
            chk("held_pc", pc, sb_q[0][63:32]);
            chk("held_inst", inst, sb_q[0][31:0]);
            if (inst_ready) void'(sb_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input bit chk_state);
      tick();
      rst_n = 1'b0;
      tick();
      if (chk_state) begin
         chk("rst_pc", pc, RST_PC);
         chk("rst_inst", inst, NOP);
         chk("rst_valid", 32'(inst_valid), 32'd0);
         chk("rst_req", 32'(imem_req), 32'd0);
         chk("rst_err", 32'(fetch_err), 32'd0);
         chk("rst_misalign", 32'(fetch_misalign), 32'd0);
      end
      tick();
      sb_q.delete();
      exp_pc     = RST_PC;
      req_cyc    = 0;
      stall_left = 0;
      ack_delay  = pick_ack_delay();
      rst_n      = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bit ok;
      int a;
      int nreq;

      // Zero-wait imem, decode always ready
      ack_fixed = 0; stall_fixed = 0;
      do_reset(1'b1);
      tick();
      chk("lat_req_c1", 32'(imem_req), 32'd1);
      chk("lat_valid_c1", 32'(inst_valid), 32'd0);
      tick();
      chk("lat_valid_c2", 32'(inst_valid), 32'd1);
      chk("lat_req_c2", 32'(imem_req), 32'd0);
      tick();
      chk("lat_req_c3", 32'(imem_req), 32'd1);
      a = n_accept;
      repeat (20) tick();
      chk("zero_wait_rate", 32'(n_accept - a), 32'd10);

      // Ack on the last allowed wait cycle, decode stalls 4 cycles
      ack_fixed = 3; stall_fixed = 4;
      do_reset(1'b0);
      a = n_accept;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (n_accept - a >= 6) ok = 1'b1;
      end
      chk("stall_progress", 32'(ok), 32'd1);
      chk("late_ack_no_err", 32'(fetch_err), 32'd0);

      // Ack never arrives
      never_ack = 1'b1;
      do_reset(1'b0);
      nreq = 0;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         if (fetch_err) ok = 1'b1;
         else if (imem_req) nreq++;
      end
      chk("timeout_err", 32'(fetch_err), 32'd1);
      chk("timeout_req_cycles", 32'(nreq), 32'd4);
      chk("timeout_req_drop", 32'(imem_req), 32'd0);
      repeat (3) tick();
      chk("err_absorb_req", 32'(imem_req), 32'd0);
      chk("err_absorb_valid", 32'(inst_valid), 32'd0);
      chk("err_sticky", 32'(fetch_err), 32'd1);
      never_ack = 1'b0;

      // Random waits and stalls through the branch and the 32-bit wrap
      ack_fixed = -1; ack_dmax = 3; stall_fixed = -1; stall_max = 3;
      do_reset(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         tick();
         if (pc == 32'hFFFF_FFFC) ok = 1'b1;
      end
      chk("reach_top_pc", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         if (pc != 32'hFFFF_FFFC) ok = 1'b1;
      end
      chk("wrap_pc", pc, 32'h0000_0000);
      repeat (300) tick();
      chk("random_no_err", 32'(fetch_err), 32'd0);

      // Reset asserted while a request is being acked
      ack_fixed = 0; stall_fixed = 0;
      do_reset(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (imem_req && imem_ack) ok = 1'b1;
         else tick();
      end
      chk("stale_ack_setup", 32'(ok), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("stale_pc", pc, RST_PC);
      chk("stale_inst", inst, NOP);
      chk("stale_valid", 32'(inst_valid), 32'd0);
      chk("stale_req", 32'(imem_req), 32'd0);
      tick();
      sb_q.delete();
      exp_pc = RST_PC; req_cyc = 0; stall_left = 0; ack_delay = 0;
      rst_n = 1'b1;
      repeat (12) tick();

      // Misaligned branch target
      mis_on = 1'b1; ack_fixed = -1; ack_dmax = 1; stall_fixed = -1; stall_max = 1;
      do_reset(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         tick();
         if (pc == 32'h0000_0102) ok = 1'b1;
      end
      chk("reach_misaligned_pc", 32'(ok), 32'd1);
`ifdef IFETCH_MISALIGN_CHECK_EN
      repeat (2) tick();
      chk("misalign_flag", 32'(fetch_misalign), 32'd1);
      chk("misalign_no_req", 32'(imem_req), 32'd0);
      chk("misalign_no_valid", 32'(inst_valid), 32'd0);
      chk("misalign_no_err", 32'(fetch_err), 32'd0);
      repeat (3) tick();
      chk("misalign_absorb_req", 32'(imem_req), 32'd0);
`else
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (imem_req) ok = 1'b1;
         else tick();
      end
      chk("misalign_req_seen", 32'(ok), 32'd1);
      chk("misalign_addr_aligned", imem_addr, 32'h0000_0100);
      chk("misalign_flag_off", 32'(fetch_misalign), 32'd0);
      repeat (20) tick();
`endif
      mis_on = 1'b0;

      chk("accept_progress", 32'(n_accept >= 40), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
